mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 128x16 program/data RAM between the processor's instruction-fetch port (read-only) and data port (read/write).
//   Grants at most one access per cycle, drives the RAM port, and routes the registered read data back to the winning requester with a valid strobe.
//   Sits between mproc and ram_128_16 inside the memory subsystem top.
// PARAMETERS
//   AW  7   address width (word addressed, 128 words)
//   DW  16  data word width
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   reset      in   1   synchronous, active-low reset
//   i_req      in   1   instruction fetch request, held until i_gnt
//   i_addr     in   AW  fetch address
//   i_gnt      out  1   fetch accepted this cycle (combinational from req/state)
//   i_rvalid   out  1   fetch data valid on rdata (one cycle after i_gnt)
//   d_req      in   1   data request, held until d_gnt
//   d_we       in   1   1 = write, 0 = read
//   d_addr     in   AW  data address
//   d_wdata    in   DW  write data
//   d_gnt      out  1   data access accepted this cycle
//   d_rvalid   out  1   data read value valid on rdata (reads only)
//   rdata      out  DW  shared return bus, equals ram_dout
//   ram_wr     out  1   RAM write enable
//   ram_addr   out  AW  RAM address
//   ram_din    out  DW  RAM write data
//   ram_dout   in   DW  RAM registered read data (1-cycle latency)
//   conflicts  out  16  count of cycles with both requests pending (perf option)
// BEHAVIOUR
//   - Reset (reset==0 at posedge): i_rvalid=0, d_rvalid=0, last_gnt=DATA, conflicts=0; gnt outputs are 0 while reset==0.
//   - Arbitration each cycle: only one req -> grant it; both -> grant the port NOT in last_gnt (round robin); none -> no grant, ram_wr=0.
//   - last_gnt updates only on a grant cycle; idle cycles keep it.
//   - First contended cycle after reset therefore grants fetch.
//   - RAM mux: ram_addr/ram_din/ram_wr come from the granted port; with no grant ram_addr=i_addr, ram_din=0, ram_wr=0.
//   - ram_wr = d_gnt & d_we; writes complete at grant, produce no rvalid.
//   - Latency: i_rvalid (or d_rvalid for reads) registered = grant of previous cycle; rdata passes ram_dout straight through. Back-to-back grants give one rvalid per cycle.
//   - Same-address write then read: read granted next cycle returns new data; a read whose grant coincides with nothing else sees RAM read-old-data semantics only for same-cycle write (not possible: one access/cycle).
//   - Requesters must hold req/addr/wdata stable until gnt; dropping req before gnt is legal and cancels the request with no side effect.
//   - Reset mid-operation: pending rvalid from the prior grant is squashed (rvalid=0 next cycle); any write granted in the reset cycle is not issued.
//   - Fairness: a continuously requesting port waits at most 1 cycle.
// CONFIGURATION
//   MEM_ARB_PERF_EN defined: conflicts increments every non-reset cycle with i_req&d_req, saturates at 16'hFFFF, cleared by reset.
//   Not defined: conflicts tied to 16'h0, no counter flops synthesized; arbitration unchanged.
// STRUCTURE
//   Shared package mem_pkg: MEM_AW=7, MEM_DW=16, enum port_id_t {PORT_IFETCH, PORT_DATA} for last_gnt.
//   One natural sub-module: rr_arb2 (2-way round-robin grant from req[1:0] + last pointer); mux, rvalid pipeline, counter stay in top.
// TESTING
//   1 reset low 3 cycles with both req high -> no gnt, rvalid=0; release -> first gnt i_gnt, i_rvalid next cycle.
//   2 i_req only, addr 0..3 back-to-back on preloaded RAM -> i_gnt each cycle, rdata 16'o000100,16'o001201,16'o002321,16'o003432 with i_rvalid one cycle later.
//   3 both req held 6 cycles -> grants alternate I,D,I,D,I,D; conflicts=6 with MEM_ARB_PERF_EN, 0 without.
//   4 d write 16'hBEEF to addr 7 then d read addr 7 -> ram_wr=1 once, no d_rvalid for write, read returns 16'hBEEF with d_rvalid.
//   5 d_req dropped before grant while fetch wins -> no ram_wr, no d_rvalid, last_gnt=IFETCH.
//   6 reset asserted the cycle after a read grant -> rvalid stays 0, RAM content unchanged at target addr.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory subsystem: RAM geometry and the
// requester identifiers used by the arbiter's round-robin pointer.
package mem_pkg;

    localparam int MEM_AW = 7;
    localparam int MEM_DW = 16;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_DATA   = 1'b1
    } port_id_t;

    // The port that wins a contended cycle when p was granted last.
    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_IFETCH) ? PORT_DATA : PORT_IFETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the program/data RAM arbiter.
// master: processor ports plus RAM model; slave: the arbiter itself.
interface mem_arbiter_if #(
    parameter int AW = mem_pkg::MEM_AW,
    parameter int DW = mem_pkg::MEM_DW
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;

    logic [DW-1:0] rdata;

    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        input  i_gnt, i_rvalid, d_gnt, d_rvalid, rdata, ram_wr, ram_addr, ram_din
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
        output i_gnt, i_rvalid, d_gnt, d_rvalid, rdata, ram_wr, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: req[0] = instruction fetch, req[1] = data.
// A contended cycle goes to the port that did not win last time.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       en,
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (other_port(last) == PORT_IFETCH) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports.
// Optional MEM_ARB_PERF_EN adds a saturating contention counter on conflicts.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic [15:0]   conflicts
);

    logic [1:0]    gnt;
    port_id_t      last_q;
    port_id_t      last_d;
    logic          i_vld_p1;
    logic          d_vld_p1;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] din_mux;
    logic          wr_mux;

    // Grants are held off while reset is low, which also blocks any write.
    rr_arb2 u_rr (
        .en   (reset),
        .req  ({bus.d_req, bus.i_req}),
        .last (last_q),
        .gnt  (gnt)
    );

    always_comb begin
        last_d   = last_q;
        addr_mux = bus.i_addr;
        din_mux  = '0;
        wr_mux   = 1'b0;
        if (gnt[0]) begin
            last_d = PORT_IFETCH;
        end else if (gnt[1]) begin
            last_d   = PORT_DATA;
            addr_mux = bus.d_addr;
            din_mux  = bus.d_wdata;
            wr_mux   = bus.d_we;
        end
    end

    // p0 -> p1: the RAM registers its read data, so valid lags the grant by one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q   <= PORT_DATA;
            i_vld_p1 <= 1'b0;
            d_vld_p1 <= 1'b0;
        end else begin
            last_q   <= last_d;
            i_vld_p1 <= gnt[0];
            d_vld_p1 <= gnt[1] & ~bus.d_we;
        end
    end

    assign bus.i_gnt    = gnt[0];
    assign bus.d_gnt    = gnt[1];
    assign bus.i_rvalid = i_vld_p1;
    assign bus.d_rvalid = d_vld_p1;
    assign bus.rdata    = bus.ram_dout;
    assign bus.ram_wr   = wr_mux;
    assign bus.ram_addr = addr_mux;
    assign bus.ram_din  = din_mux;

`ifdef MEM_ARB_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] conf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            conf_q <= '0;
        end else if (bus.i_req & bus.d_req) begin
            conf_q <= sat_inc16(conf_q);
        end
    end

    assign conflicts = conf_q;
`else
    assign conflicts = 16'h0;
`endif

endmodule
